// File: rtl/alu_exec_unit_pkg.sv
// Shared types for the execute-stage ALU unit.
// Opcodes, operand sources, NZCV status and FSM state.
package alu_exec_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_EOR = 4'd4,
    ALU_MOV = 4'd5
  } alu_control_signal;

  typedef enum logic [2:0] {
    FROM_REG         = 3'd0,
    FROM_IMM         = 3'd1,
    FROM_ZERO        = 3'd2,
    FROM_ACCUMULATOR = 3'd3
  } alu_input_source;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_register;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } alu_exec_state;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU core for single-cycle ops.
// Produces the result and a full NZCV set; SUB carry is ARM-style no-borrow.
module alu_core
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_control_signal ctrl,
  output logic [WIDTH-1:0] result,
  output status_register   flags
);

  logic [WIDTH:0] add_s;
  logic [WIDTH:0] sub_s;

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b}
               + (WIDTH+1)'(1);

  always_comb begin
    result  = '0;
    flags   = '0;
    unique case (ctrl)
      ALU_ADD: begin
        result  = add_s[WIDTH-1:0];
        flags.c = add_s[WIDTH];
        flags.v = (a[WIDTH-1] == b[WIDTH-1])
                & (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result  = sub_s[WIDTH-1:0];
        flags.c = sub_s[WIDTH];
        flags.v = (a[WIDTH-1] != b[WIDTH-1])
                & (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_ORR: result = a | b;
      ALU_EOR: result = a ^ b;
      ALU_MOV: result = b;
      default: result = '0;
    endcase
    flags.n = result[WIDTH-1];
    flags.z = (result == '0);
  end

endmodule

// File: rtl/alu_iter_mul.sv
// Iterative radix-2^BITS shift-add multiplier, low WIDTH bits of product.
// start reloads operands at any time; done marks the final iteration cycle.
module alu_iter_mul #(
  parameter int WIDTH = 32,
  parameter int BITS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int N  = WIDTH / BITS;
  localparam int CW = $clog2(N + 1);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [BITS-1:0]  digit;

  assign digit = mplier[BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CW'(N);
      mcand  <= a;
      mplier <= b;
      prod   <= '0;
    end else if (run) begin
      // bits shifted out of mcand are above WIDTH and never needed
      prod   <= prod + mcand * WIDTH'(digit);
      mcand  <= mcand << BITS;
      mplier <= mplier >> BITS;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

  assign done    = run && (cnt == CW'(1));
  assign product = prod;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: operand mux, handshake, multiply FSM, NZCV commit.
// Multiply results are presented in DONE and committed unless flushed.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MUL_BITS_PER = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              is_mul_i,
  input  alu_control_signal alu_ctrl_sig_i,
  input  logic              update_flag_i,
  input  alu_input_source   src1_sel_i,
  input  alu_input_source   src2_sel_i,
  input  logic [WIDTH-1:0]  reg_data_1_i,
  input  logic [WIDTH-1:0]  reg_data_2_i,
  input  logic [WIDTH-1:0]  accumulator_i,
  input  logic [WIDTH-1:0]  immediate_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  alu_result_o,
  output status_register    status_reg_o,
  output logic              busy_o
);

  alu_exec_state    state;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] core_res;
  status_register   core_flags;
  logic [WIDTH-1:0] mul_prod;
  logic             mul_done;
  status_register   mul_flags;
  logic [WIDTH-1:0] result_q;
  status_register   status_q;
  logic             valid_q;
  logic             upd_q;
  logic             accept;
  logic             done_ok;

  always_comb begin
    op1 = '0;
    case (src1_sel_i)
      FROM_REG:         op1 = reg_data_1_i;
      FROM_IMM:         op1 = immediate_i;
      FROM_ZERO:        op1 = '0;
      FROM_ACCUMULATOR: op1 = accumulator_i;
      default:          op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (src2_sel_i)
      FROM_REG:         op2 = reg_data_2_i;
      FROM_IMM:         op2 = immediate_i;
      FROM_ZERO:        op2 = '0;
      FROM_ACCUMULATOR: op2 = accumulator_i;
      default:          op2 = '0;
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (op1),
    .b      (op2),
    .ctrl   (alu_ctrl_sig_i),
    .result (core_res),
    .flags  (core_flags)
  );

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign accept  = valid_i && ready_o && !flush_i;

  alu_iter_mul #(
    .WIDTH (WIDTH),
    .BITS  (MUL_BITS_PER)
  ) u_mul (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .start   (accept && is_mul_i),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (mul_prod)
  );

  // MULS only touches N and Z
  always_comb begin
    mul_flags   = status_q;
    mul_flags.n = mul_prod[WIDTH-1];
    mul_flags.z = (mul_prod == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      result_q <= '0;
      status_q <= '0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul_i) begin
              state <= MUL_RUN;
              upd_q <= update_flag_i;
            end else begin
              result_q <= core_res;
              valid_q  <= 1'b1;
              if (update_flag_i) status_q <= core_flags;
            end
          end
        end
        MUL_RUN: begin
          if (flush_i)       state <= IDLE;
          else if (mul_done) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          if (!flush_i) begin
            result_q <= mul_prod;
            if (upd_q) status_q <= mul_flags;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done_ok      = (state == DONE) && !flush_i;
  assign valid_o      = valid_q || done_ok;
  assign alu_result_o = done_ok ? mul_prod : result_q;
  assign status_reg_o = (done_ok && upd_q) ? mul_flags
                                           : status_q;

endmodule
